// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch stage issuing word-aligned imem requests from
//            the PC and buffering PC-tagged responses in a small FIFO to decode.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic            pc_advance,
   input  logic            flush,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready
);

   localparam int c_pw = $clog2(DEPTH);
   localparam int c_cw = c_pw + 1;

   // Live fetches are split into tagged (r_outstanding) and flushed (r_drop_cnt);
   // the flushed ones are always the oldest, so they return first.
   logic [c_cw-1:0] r_outstanding;
   logic [c_cw-1:0] r_drop_cnt;
   logic [c_cw-1:0] r_count;
   logic [c_pw-1:0] r_tag_wr;
   logic [c_pw-1:0] r_tag_rd;
   logic [c_pw-1:0] r_head;
   logic [c_pw-1:0] r_tail;

   logic [XLEN-1:0] r_tag_mem   [DEPTH];
   logic [XLEN-1:0] r_pc_mem    [DEPTH];
   logic [XLEN-1:0] r_instr_mem [DEPTH];

   logic [c_cw+1:0] w_credit_sum;
   logic [XLEN-1:0] w_aligned_pc;
   logic            w_req_valid;
   logic            w_accept;
   logic            w_rsp_live;
   logic            w_rsp_drop;
   logic            w_rsp_tagged;
   logic            w_enq;
   logic            w_deq;

   assign w_aligned_pc = pc & ~XLEN'(3);
   assign w_credit_sum = {2'b00, r_outstanding} + {2'b00, r_drop_cnt} + {2'b00, r_count};

   // Credit uses registered occupancy only, so a same-cycle dequeue adds nothing.
   assign w_req_valid  = !rst && !flush && (w_credit_sum < (c_cw+2)'(DEPTH));
   assign w_accept     = w_req_valid && imem_req_ready;

   assign w_rsp_live   = imem_rsp_valid && ((r_outstanding != '0) || (r_drop_cnt != '0));
   assign w_rsp_drop   = w_rsp_live && (r_drop_cnt != '0);
   assign w_rsp_tagged = w_rsp_live && (r_drop_cnt == '0);
   assign w_enq        = w_rsp_tagged && !flush;
   assign w_deq        = if_valid && if_ready;

   assign pc_advance     = w_accept;
   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = rst ? '0 : w_aligned_pc;

   assign if_valid = (r_count != '0);
   assign if_instr = if_valid ? r_instr_mem[r_head] : '0;
   assign if_pc    = if_valid ? r_pc_mem[r_head]    : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_tag_wr      <= '0;
         r_tag_rd      <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else if (flush) begin
         // Every fetch still in flight becomes a drop; a response arriving now
         // retires one of them.
         r_drop_cnt    <= r_drop_cnt + r_outstanding - c_cw'(w_rsp_live);
         r_outstanding <= '0;
         r_count       <= '0;
         r_tag_wr      <= '0;
         r_tag_rd      <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else begin
         r_outstanding <= r_outstanding + c_cw'(w_accept) - c_cw'(w_rsp_tagged);
         r_drop_cnt    <= r_drop_cnt - c_cw'(w_rsp_drop);
         r_count       <= r_count + c_cw'(w_enq) - c_cw'(w_deq);
         if (w_accept)     r_tag_wr <= r_tag_wr + c_pw'(1);
         if (w_rsp_tagged) r_tag_rd <= r_tag_rd + c_pw'(1);
         if (w_enq)        r_tail   <= r_tail + c_pw'(1);
         if (w_deq)        r_head   <= r_head + c_pw'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_tag_mem[r_tag_wr] <= w_aligned_pc;
      if (w_enq) begin
         r_pc_mem[r_tail]    <= r_tag_mem[r_tag_rd];
         r_instr_mem[r_tail] <= imem_rsp_data;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_enq && !w_deq && (r_count == c_cw'(DEPTH))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed and randomized bench for if_fetch_queue against a
//            queue-based reference of in-flight fetches and buffered entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] pc;
   logic            pc_advance;
   logic            flush;
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_ready;

   if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .flush(flush),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .if_ready(if_ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit dropped; } infl_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   infl_t       inflight[$];
   ent_t        fifo_q[$];
   logic [31:0] mem_pending[$];

   int n_pass  = 0;
   int n_total = 0;
   int rsp_mode;
   bit stray_rsp;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_clear();
      inflight.delete();
      fifo_q.delete();
      mem_pending.delete();
   endtask

   // One clock: drive response, compare outputs at negedge, advance model at posedge.
   task automatic cycle();
      logic  e_valid, e_adv;
      bit    deq;
      infl_t e;
      ent_t  n;
      case (rsp_mode)
         1:       imem_rsp_valid = (mem_pending.size() > 0);
         2:       imem_rsp_valid = (mem_pending.size() > 0) && ($urandom_range(0, 2) != 0);
         default: imem_rsp_valid = stray_rsp;
      endcase
      imem_rsp_data = $urandom;
      @(negedge clk);
      e_valid = !flush && ((inflight.size() + fifo_q.size()) < DEPTH);
      e_adv   = e_valid && imem_req_ready;
      check("req_valid", imem_req_valid, e_valid);
      check("pc_advance", pc_advance, e_adv);
      if (e_valid) check("req_addr", imem_req_addr, {pc[31:2], 2'b00});
      check("if_valid", if_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
         check("if_pc", if_pc, fifo_q[0].pc);
         check("if_instr", if_instr, fifo_q[0].instr);
      end
      @(posedge clk);
      deq = (fifo_q.size() != 0) && if_ready;
      if (imem_rsp_valid && inflight.size() > 0) begin
         e = inflight.pop_front();
         if (!e.dropped && !flush) begin
            n.pc = e.pc;
            n.instr = imem_rsp_data;
            fifo_q.push_back(n);
         end
      end
      if (imem_rsp_valid && mem_pending.size() > 0) void'(mem_pending.pop_front());
      if (flush) begin
         fifo_q.delete();
         foreach (inflight[i]) inflight[i].dropped = 1'b1;
      end else if (deq) begin
         void'(fifo_q.pop_front());
      end
      if (e_adv) begin
         e.pc = {pc[31:2], 2'b00};
         e.dropped = 1'b0;
         inflight.push_back(e);
         mem_pending.push_back(e.pc);
      end
      #1;
      if (e_adv) pc = pc + 32'd4;
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_adv"}, pc_advance, 1'b0);
      check({tag, "_req_valid"}, imem_req_valid, 1'b0);
      check({tag, "_req_addr"}, imem_req_addr, 32'h0);
      check({tag, "_if_valid"}, if_valid, 1'b0);
      check({tag, "_if_instr"}, if_instr, 32'h0);
      check({tag, "_if_pc"}, if_pc, 32'h0);
   endtask

   task automatic do_reset(logic [31:0] start_pc);
      rst = 1'b1;
      flush = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      if_ready = 1'b0;
      rsp_mode = 0;
      stray_rsp = 1'b0;
      pc = start_pc;
      @(posedge clk);
      #1;
      check_all_zero("reset");
      #2 rst = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      // Test 1: streaming with latency-1 memory.
      do_reset(32'h0);
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      rsp_mode = 1;
      check("t1_first_addr", imem_req_addr, 32'h0);
      for (int i = 0; i < 6; i++) cycle();

      // Test 2: decode stalled, queue fills, then drains in order.
      do_reset(32'h0);
      imem_req_ready = 1'b1;
      rsp_mode = 1;
      for (int i = 0; i < 4; i++) cycle();
      check("t2_stalled_valid", imem_req_valid, 1'b0);
      check("t2_head_pc", if_pc, 32'h0);
      if_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();

      // Test 3: memory back-pressure holds the request.
      do_reset(32'h103);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_hold_valid", imem_req_valid, 1'b1);
         check("t3_hold_addr", imem_req_addr, 32'h100);
         check("t3_hold_adv", pc_advance, 1'b0);
         cycle();
      end
      imem_req_ready = 1'b1;
      cycle();
      imem_req_ready = 1'b0;
      check("t3_single_accept", inflight.size(), 1);
      for (int i = 0; i < 2; i++) cycle();

      // Test 4: flush with two fetches in flight.
      do_reset(32'h10);
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      cycle();
      cycle();
      flush = 1'b1;
      pc = 32'h200;
      cycle();
      flush = 1'b0;
      rsp_mode = 1;
      k = 0;
      while (!if_valid && k < 12) begin
         cycle();
         k++;
      end
      check("t4_delivered", if_valid, 1'b1);
      check("t4_first_pc", if_pc, 32'h200);
      for (int i = 0; i < 3; i++) cycle();

      // Test 5: flush coincident with a response.
      do_reset(32'h40);
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      cycle();
      cycle();
      rsp_mode = 1;
      flush = 1'b1;
      pc = 32'h300;
      cycle();
      flush = 1'b0;
      #1;
      check("t5_one_drop_left", imem_req_valid, 1'b1);
      k = 0;
      while (!if_valid && k < 12) begin
         cycle();
         k++;
      end
      check("t5_first_pc", if_pc, 32'h300);
      for (int i = 0; i < 3; i++) cycle();

      // Test 6: asynchronous reset mid-stream, then a stray response.
      do_reset(32'h500);
      imem_req_ready = 1'b1;
      cycle();
      rsp_mode = 1;
      cycle();
      rsp_mode = 0;
      check("t6_pre_if_valid", if_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("t6_async");
      @(posedge clk);
      #2 rst = 1'b0;
      model_clear();
      imem_req_ready = 1'b0;
      stray_rsp = 1'b1;
      cycle();
      stray_rsp = 1'b0;
      cycle();
      check("t6_stray_ignored", if_valid, 1'b0);

      // Randomized traffic including flushes and unaligned PCs.
      do_reset($urandom);
      rsp_mode = 2;
      for (int i = 0; i < 400; i++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         if_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 15) == 0);
         if (flush) pc = $urandom;
         cycle();
      end
      flush = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
